// File: rtl/hex_display_pkg.sv
// Shared definitions for the two-digit hex display: segment type, the
// gfedcba decode table for all sixteen nibble values, and a lookup helper.
package pkg_hex;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Active-high segments, bit order {g,f,e,d,c,b,a}.
  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t nib_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-segment decoder; a thin wrapper around the package
// lookup so the decode can be exercised on its own.
module hex_to_seg
  import pkg_hex::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    seg = nib_to_seg(nib);
  end

endmodule

// File: rtl/hex_display.sv
// Two-digit multiplexed 7-segment driver: a free-running divider toggles the
// digit select every DIV cycles, and the output register shows the matching nibble.
module hex_display
  import pkg_hex::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int REFRESH_HZ = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hex_val,
  output logic [7:0] hex_pins
);

  localparam int DIV   = CLK_FREQ / REFRESH_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  if ((DIV < 2) || ((CLK_FREQ % REFRESH_HZ) != 0)) begin : g_bad_div
    $error("hex_display: CLK_FREQ/REFRESH_HZ must be an integer >= 2");
  end

  logic [CNT_W-1:0] cnt;
  logic             sel;
  logic [3:0]       nib;
  seg_t             seg;

  always_comb begin
    nib = sel ? hex_val[7:4] : hex_val[3:0];
  end

  hex_to_seg u_hex_to_seg (
    .nib (nib),
    .seg (seg)
  );

  // The output uses the pre-edge sel, so a digit's pins lag its select by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sel      <= 1'b0;
      hex_pins <= 8'h00;
    end else begin
      hex_pins <= {sel, seg};
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        sel <= ~sel;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hex_display.sv
// Bench for hex_display with DIV=4: directed vectors with literal expectations,
// plus a cycle-count model feeding an expected queue checked on every falling edge.
module tb_hex_display;

  localparam int CLK_FREQ   = 8;
  localparam int REFRESH_HZ = 2;
  localparam int DIV        = CLK_FREQ / REFRESH_HZ;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hex_val = 8'h00;
  logic [7:0] hex_pins;

  always #5 clk = ~clk;

  hex_display #(
    .CLK_FREQ   (CLK_FREQ),
    .REFRESH_HZ (REFRESH_HZ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hex_val  (hex_val),
    .hex_pins (hex_pins)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model: the digit shown after the k-th edge since reset is floor(k/DIV) mod 2
  logic [6:0] seg_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [7:0] exp_q [$];
  int         edges_since_rst = 0;
  logic       m_sel;
  logic [3:0] m_nib;

  always @(posedge clk) begin
    if (rst) begin
      edges_since_rst = 0;
      exp_q.push_back(8'h00);
    end else begin
      m_sel = ((edges_since_rst / DIV) % 2) == 1;
      m_nib = m_sel ? hex_val[7:4] : hex_val[3:0];
      exp_q.push_back({m_sel, seg_tbl[m_nib]});
      edges_since_rst = edges_since_rst + 1;
    end
  end

  // scoreboard compare
  logic [7:0] sb_exp;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      n_checks++;
      if (hex_pins !== sb_exp) begin
        n_errors++;
        $display("FAIL model t=%0t: hex_pins=%h expected=%h", $time, hex_pins, sb_exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [7:0] exp);
    n_checks++;
    if (hex_pins !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: hex_pins=%h expected=%h", name, $time, hex_pins, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] v);
    rst     = 1'b1;
    hex_val = v;
    tick();
    tick();
    check_lit("reset", 8'h00);
    rst = 1'b0;
  endtask

  logic [7:0] mux_exp [9] = '{8'h77, 8'h77, 8'h77, 8'h77,
                              8'hCF, 8'hCF, 8'hCF, 8'hCF, 8'h77};
  logic [7:0] dec_exp [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  initial begin
    tick();

    // reset and multiplex period
    do_reset(8'h3A);
    for (int e = 0; e < 9; e++) begin
      tick();
      check_lit("mux", mux_exp[e]);
    end

    // full decode on digit 0
    for (int i = 0; i < 16; i++) begin
      do_reset(8'h30 | 8'(i));
      tick();
      check_lit("decode", dec_exp[i]);
    end

    // mid-period change during a sel=1 window
    do_reset(8'h3A);
    repeat (5) tick();
    check_lit("mid_pre", 8'hCF);
    hex_val = 8'h5A;
    tick();
    check_lit("mid_change", 8'hED);
    tick();
    tick();
    check_lit("mid_hold", 8'hED);
    tick();
    check_lit("mid_wrap", 8'h77);

    // reset in the 3rd cycle of a sel=1 window
    do_reset(8'h3A);
    repeat (6) tick();
    check_lit("rst_mid_pre", 8'hCF);
    rst = 1'b1;
    tick();
    check_lit("rst_mid", 8'h00);
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      check_lit("rst_mid_d0", 8'h77);
    end
    tick();
    check_lit("rst_mid_d1", 8'hCF);

    // boundaries
    do_reset(8'h00);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_lit("zero", (e < 4) ? 8'h3F : 8'hBF);
    end
    do_reset(8'hFF);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_lit("ones", (e < 4) ? 8'h71 : 8'hF1);
    end

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
